// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, NOP encoding and default reset PC.
// FETCH_MISALIGN_EN adds the FAULT state for misaligned redirect targets.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
`ifdef FETCH_MISALIGN_EN
    S_FAULT,
`endif
    S_DROP
  } fetch_state_t;

  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] next_word(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// IF/ID output register plus a one-entry skid slot for responses that land during a stall.
// FETCH_MISALIGN_EN adds a misalign flag that travels with the output register.
module fetch_buffer
  import cpu_pkg::*;
(
  input  logic        clock,
  input  logic        resetN,
  input  logic        load,
  input  logic        consume,
  input  logic        flush,
  input  logic [31:0] load_data,
  input  logic [31:0] load_pc,
`ifdef FETCH_MISALIGN_EN
  input  logic        load_misalign,
  output logic        misalign,
`endif
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        inst_valid
);

  logic [31:0] skid_data;
  logic [31:0] skid_pc;
  logic        skid_full;
  logic        load_out;
  logic        load_skid;

  assign load_out  = load && (!inst_valid || consume);
  assign load_skid = load && inst_valid && !consume;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      instruction <= NOP;
      pc          <= 32'h0;
      inst_valid  <= 1'b0;
      skid_full   <= 1'b0;
`ifdef FETCH_MISALIGN_EN
      misalign    <= 1'b0;
`endif
    end else if (flush) begin
      inst_valid <= 1'b0;
      skid_full  <= 1'b0;
`ifdef FETCH_MISALIGN_EN
      misalign   <= 1'b0;
`endif
    end else if (load_out) begin
      instruction <= load_data;
      pc          <= load_pc;
      inst_valid  <= 1'b1;
`ifdef FETCH_MISALIGN_EN
      misalign    <= load_misalign;
`endif
    end else if (load_skid) begin
      skid_full <= 1'b1;
    end else if (consume && skid_full) begin
      instruction <= skid_data;
      pc          <= skid_pc;
      skid_full   <= 1'b0;
`ifdef FETCH_MISALIGN_EN
      misalign    <= 1'b0;
`endif
    end else if (consume) begin
      inst_valid <= 1'b0;
`ifdef FETCH_MISALIGN_EN
      misalign   <= 1'b0;
`endif
    end
  end

  // Skid payload needs no reset: it is only read while skid_full is set.
  always_ff @(posedge clock) begin
    if (load_skid) begin
      skid_data <= load_data;
      skid_pc   <= load_pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem handshake, redirect handling.
// FETCH_MISALIGN_EN enables the misalign port and FAULT state for misaligned redirects.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        enable,
  input  logic        redirect,
  input  logic [31:0] redirectPc,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemGnt,
  input  logic        imemValid,
  input  logic [31:0] imemData,
`ifdef FETCH_MISALIGN_EN
  output logic        misalign,
`endif
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        instValid
);

  fetch_state_t state;
  logic [31:0]  pc_reg;
  logic [31:0]  req_pc;
  logic [31:0]  redirect_target;
  logic         can_load;
  logic         rsp_load;
  logic         gnt;
  logic         buf_load;
  logic [31:0]  buf_data;
  logic [31:0]  buf_pc;
  logic         redirect_bad;
  logic         fault_load;

`ifdef FETCH_MISALIGN_EN
  logic fault_sent;
  assign redirect_target = redirectPc;
  assign redirect_bad    = |redirectPc[1:0];
  assign fault_load      = (state == S_FAULT) && !fault_sent && can_load;
`else
  assign redirect_target = redirectPc & ~32'd3;
  assign redirect_bad    = 1'b0;
  assign fault_load      = 1'b0;
`endif

  assign can_load = !instValid || enable;
  assign rsp_load = (state == S_WAIT) && imemValid && can_load;
  assign imemAddr = pc_reg;
  assign gnt      = imemReq && imemGnt;

  always_comb begin
    imemReq = 1'b0;
    if (resetN && !redirect) begin
      if (state == S_REQ) imemReq = 1'b1;
      else                imemReq = rsp_load;
    end
  end

  // Responses in the redirect cycle are never loaded; fault loads carry a NOP.
  assign buf_load = !redirect && (((state == S_WAIT) && imemValid) || fault_load);
  assign buf_data = fault_load ? NOP : imemData;
  assign buf_pc   = fault_load ? pc_reg : req_pc;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state  <= S_REQ;
      pc_reg <= RESET_PC;
`ifdef FETCH_MISALIGN_EN
      fault_sent <= 1'b0;
`endif
    end else if (redirect) begin
      pc_reg <= redirect_target;
      if (redirect_bad) begin
`ifdef FETCH_MISALIGN_EN
        state      <= S_FAULT;
        fault_sent <= 1'b0;
`endif
      end else if ((state == S_WAIT || state == S_DROP) && !imemValid) begin
        state <= S_DROP;
      end else begin
        state <= S_REQ;
      end
    end else begin
      case (state)
        S_REQ: begin
          if (gnt) begin
            pc_reg <= next_word(pc_reg);
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imemValid) begin
            if (!can_load) begin
              state <= S_HOLD;
            end else if (gnt) begin
              pc_reg <= next_word(pc_reg);
              state  <= S_WAIT;
            end else begin
              state <= S_REQ;
            end
          end
        end
        S_HOLD: if (enable) state <= S_REQ;
        S_DROP: if (imemValid) state <= S_REQ;
`ifdef FETCH_MISALIGN_EN
        S_FAULT: if (fault_load) fault_sent <= 1'b1;
`endif
        default: state <= S_REQ;
      endcase
    end
  end

  // Address of the read in flight; only meaningful once a grant has happened.
  always_ff @(posedge clock) begin
    if (gnt) req_pc <= pc_reg;
  end

  fetch_buffer u_buffer (
    .clock        (clock),
    .resetN       (resetN),
    .load         (buf_load),
    .consume      (enable),
    .flush        (redirect),
    .load_data    (buf_data),
    .load_pc      (buf_pc),
`ifdef FETCH_MISALIGN_EN
    .load_misalign(fault_load),
    .misalign     (misalign),
`endif
    .instruction  (instruction),
    .pc           (pc),
    .inst_valid   (instValid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory model with variable latency and a consumption scoreboard.
// Define FETCH_MISALIGN_EN to exercise the misaligned-redirect fault path.
module tb_fetch_stage;

  logic        clock = 1'b0;
  logic        resetN = 1'b0;
  logic        enable = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirectPc = 32'h0;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemGnt = 1'b1;
  logic        imemValid = 1'b0;
  logic [31:0] imemData = 32'h0;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        instValid;
`ifdef FETCH_MISALIGN_EN
  logic        misalign;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          vectors = 0;
  int          miscompares = 0;
  int          lat = 1;
  int          grants = 0;
  logic [31:0] last_addr = 32'h0;

  fetch_stage dut (
    .clock      (clock),
    .resetN     (resetN),
    .enable     (enable),
    .redirect   (redirect),
    .redirectPc (redirectPc),
    .imemReq    (imemReq),
    .imemAddr   (imemAddr),
    .imemGnt    (imemGnt),
    .imemValid  (imemValid),
    .imemData   (imemData),
`ifdef FETCH_MISALIGN_EN
    .misalign   (misalign),
`endif
    .instruction(instruction),
    .pc         (pc),
    .instValid  (instValid)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic push(input logic [31:0] p);
    sb.push_back('{pc: p, inst: memf(p)});
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    enable = 1'b0;
  endtask

  task automatic wait_grant(input int g0, input int budget);
    int n = 0;
    while (grants == g0 && n < budget) begin
      step();
      n++;
    end
    chk("grant seen", 32'(grants != g0), 32'd1);
  endtask

  // Instruction memory: grant always, response `lat` cycles after the grant edge.
  initial begin : mem_model
    logic        acc;
    logic [31:0] a;
    logic [31:0] pend;
    int          cnt;
    cnt  = 0;
    pend = 32'h0;
    forever begin
      @(negedge clock);
      acc = resetN && imemReq && imemGnt;
      a   = imemAddr;
      if (acc) begin
        grants++;
        last_addr = a;
      end
      @(posedge clock);
      #1;
      imemValid = 1'b0;
      if (!resetN) begin
        cnt = 0;
      end else begin
        if (acc) begin
          chk("single outstanding read", 32'(cnt), 32'd0);
          pend = a;
          cnt  = lat;
        end
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            imemValid = 1'b1;
            imemData  = memf(pend);
          end
        end
      end
    end
  end

  // An output is consumed at an edge with instValid and enable and no redirect.
  always @(negedge clock) begin
    if (resetN && instValid && enable && !redirect) begin
      vectors++;
      assert (sb.size() > 0)
      else begin
        miscompares++;
        $error("FAIL unexpected output: pc %h observed with empty scoreboard", pc);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("consumed pc", pc, e.pc);
        chk("consumed instruction", instruction, e.inst);
      end
    end
  end

  initial begin : watchdog
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n;
    int g0;

    repeat (3) step();
    chk("reset instValid", 32'(instValid), 32'd0);
    chk("reset imemReq", 32'(imemReq), 32'd0);
    chk("reset instruction", instruction, 32'h0);
    chk("reset pc", pc, 32'h0);
`ifdef FETCH_MISALIGN_EN
    chk("reset misalign", 32'(misalign), 32'd0);
`endif

    // Zero-wait stream, then a 3-cycle stall while 0x8 is presented
    push(32'h0); push(32'h4); push(32'h8); push(32'hC); push(32'h10);
    resetN = 1'b1;
    enable = 1'b1;
    #1;
    chk("first req", 32'(imemReq), 32'd1);
    chk("first addr", imemAddr, 32'h0);
    n = 0;
    while (!instValid && n < 10) begin
      step();
      n++;
    end
    chk("stream pc0", pc, 32'h0);
    chk("stream valid0", 32'(instValid), 32'd1);
    step();
    chk("stream pc1", pc, 32'h4);
    chk("stream valid1", 32'(instValid), 32'd1);
    step();
    chk("stream pc2", pc, 32'h8);
    chk("stream valid2", 32'(instValid), 32'd1);
    enable = 1'b0;
    repeat (3) begin
      step();
      chk("stall pc held", pc, 32'h8);
      chk("stall valid held", 32'(instValid), 32'd1);
      chk("hold no req", 32'(imemReq), 32'd0);
    end
    enable = 1'b1;
    step();
    chk("skid released", pc, 32'hC);
    drain(20);

    // Redirect while waiting on a 3-cycle read
    step();
    lat        = 3;
    redirect   = 1'b1;
    redirectPc = 32'h40;
    step();
    redirect = 1'b0;
    g0 = grants;
    wait_grant(g0, 10);
    chk("pre-redirect addr", last_addr, 32'h40);
    redirect   = 1'b1;
    redirectPc = 32'h100;
    enable     = 1'b1;
    push(32'h100); push(32'h104);
    #1;
    chk("redirect cycle no req", 32'(imemReq), 32'd0);
    step();
    redirect = 1'b0;
    #1;
    chk("drop no req", 32'(imemReq), 32'd0);
    drain(40);

    // Redirect in the same cycle as the response
    step();
    lat        = 2;
    redirect   = 1'b1;
    redirectPc = 32'h80;
    step();
    redirect = 1'b0;
    g0 = grants;
    wait_grant(g0, 10);
    chk("pre-redirect addr 2", last_addr, 32'h80);
    step();
    chk("response present", 32'(imemValid), 32'd1);
    redirect   = 1'b1;
    redirectPc = 32'h100;
    enable     = 1'b1;
    push(32'h100); push(32'h104);
    #1;
    chk("same-cycle no req", 32'(imemReq), 32'd0);
    step();
    redirect = 1'b0;
    #1;
    chk("restart req", 32'(imemReq), 32'd1);
    chk("restart addr", imemAddr, 32'h100);
    drain(30);

    // PC wraps past the top of the address space
    step();
    lat        = 1;
    redirect   = 1'b1;
    redirectPc = 32'hFFFF_FFFC;
    enable     = 1'b1;
    push(32'hFFFF_FFFC); push(32'h0); push(32'h4);
    step();
    redirect = 1'b0;
    drain(30);

`ifdef FETCH_MISALIGN_EN
    step();
    redirect   = 1'b1;
    redirectPc = 32'h102;
    enable     = 1'b1;
    sb.push_back('{pc: 32'h102, inst: 32'h0});
    step();
    redirect = 1'b0;
    #1;
    chk("fault no req", 32'(imemReq), 32'd0);
    step();
    chk("fault valid", 32'(instValid), 32'd1);
    chk("fault pc", pc, 32'h102);
    chk("fault instruction", instruction, 32'h0);
    chk("fault misalign", 32'(misalign), 32'd1);
    repeat (3) begin
      step();
      chk("fault idle req", 32'(imemReq), 32'd0);
      chk("fault idle valid", 32'(instValid), 32'd0);
    end
    redirect   = 1'b1;
    redirectPc = 32'h200;
    push(32'h200);
    step();
    redirect = 1'b0;
    #1;
    chk("post-fault req", 32'(imemReq), 32'd1);
    chk("post-fault addr", imemAddr, 32'h200);
    chk("post-fault misalign", 32'(misalign), 32'd0);
    drain(20);
`else
    step();
    redirect   = 1'b1;
    redirectPc = 32'h106;
    enable     = 1'b1;
    push(32'h104);
    step();
    redirect = 1'b0;
    #1;
    chk("aligned redirect addr", imemAddr, 32'h104);
    drain(20);
`endif

    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
